// File: rtl/cpu_pipe_pkg.sv
// cpu_pipe_pkg: shared EX->MEM pipeline types, default widths and skid-buffer state encoding
package cpu_pipe_pkg;
  localparam int XLEN_DEF = 32;
  localparam int RA_W_DEF = 5;
  typedef struct packed {
    logic [XLEN_DEF-1:0] result;
    logic [XLEN_DEF-1:0] store_data;
    logic [RA_W_DEF-1:0] rd;
    logic                reg_wr_en;
    logic                flag;
  } ex_mem_t;
  typedef enum logic [1:0] {EMPTY, FULL, SKID} skid_state_e;
endpackage

// File: rtl/pipe_skid_buf.sv
// pipe_skid_buf: width-W valid/ready register with one-entry skid, registered in_ready, sync flush (ports: clk, rst, flush, in_valid/in_ready/in_data, out_valid/out_ready/out_data)
module pipe_skid_buf
  import cpu_pipe_pkg::*;
#(
  parameter int W = $bits(ex_mem_t)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  skid_state_e st;
  logic [W-1:0] m, s;
  logic acc, drn;
  assign acc = in_valid & in_ready;
  assign drn = out_valid & out_ready;
  assign out_data = m;
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= EMPTY;
      in_ready <= 1'b1;
      out_valid <= 1'b0;
      m <= '0;
      s <= '0;
    end else if (flush) begin
      st <= EMPTY;
      in_ready <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (st)
        EMPTY: if (acc) begin
          st <= FULL;
          m <= in_data;
          out_valid <= 1'b1;
        end
        FULL: if (acc && drn) m <= in_data;
        else if (acc) begin
          st <= SKID;
          s <= in_data;
          in_ready <= 1'b0;
        end else if (drn) begin
          st <= EMPTY;
          out_valid <= 1'b0;
        end
        SKID: if (drn) begin
          st <= FULL;
          m <= s;
          in_ready <= 1'b1;
        end
        default: begin
          st <= EMPTY;
          in_ready <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: rtl/ex_mem_skid_stage.sv
// ex_mem_skid_stage: EX->MEM boundary register with skid buffer, flush, rd==0 write gating and hazard forwarding tap (ports: clk, rst, flush, in_* from EX, out_* to MEM, fwd_* to hazard unit)
module ex_mem_skid_stage
  import cpu_pipe_pkg::*;
#(
  parameter int XLEN        = XLEN_DEF,
  parameter int RA_W        = RA_W_DEF,
  parameter bit ZERO_REG_WR = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_result,
  input  logic [XLEN-1:0] in_store_data,
  input  logic [RA_W-1:0] in_rd,
  input  logic            in_reg_wr_en,
  input  logic            in_flag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [XLEN-1:0] out_store_data,
  output logic [RA_W-1:0] out_rd,
  output logic            out_reg_wr_en,
  output logic            out_flag,
  output logic            fwd_valid,
  output logic [RA_W-1:0] fwd_rd,
  output logic [XLEN-1:0] fwd_data
);
  typedef struct packed {
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] store_data;
    logic [RA_W-1:0] rd;
    logic            reg_wr_en;
    logic            flag;
  } ent_t;
  ent_t d, q;
  // x0 is hardwired; drop its write enable at capture unless explicitly allowed
  assign d = '{in_result, in_store_data, in_rd, in_reg_wr_en & (ZERO_REG_WR || in_rd != '0), in_flag};
  pipe_skid_buf #(.W($bits(ent_t))) u_buf (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (d),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (q)
  );
  assign out_result     = q.result;
  assign out_store_data = q.store_data;
  assign out_rd         = q.rd;
  assign out_reg_wr_en  = q.reg_wr_en;
  assign out_flag       = q.flag;
  assign fwd_valid      = out_valid & q.reg_wr_en;
  assign fwd_rd         = q.rd;
  assign fwd_data       = q.result;
endmodule
